// File: rtl/riscv_definitions.sv
// Shared RISC-V core definitions: datapath widths and the write-back request record
// used by the register-file write-back arbiter.
package riscv_definitions;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR   = 5;
    localparam int WB_MAX_REQ = 8;

    typedef struct packed {
        logic [REG_ADDR-1:0]   addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last granted
// index and the first asserted request wins. Produces a one-hot grant and its index.
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDW-1:0]     grant_idx_o,
    output logic               grant_valid_o
);

    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = IDW'((int'(last_i) + off) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_o     = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
        grant_valid_o = found;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between NUM_REQ write-back sources
// through a registered output stage. Define RF_WB_FWD_EN to add write-back forwarding ports.
module regfile_wb_arbiter
    import riscv_definitions::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*REG_ADDR-1:0]    i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
    output logic                           o_wr_reg_en,
    output logic [REG_ADDR-1:0]            o_write_register_addr,
    output logic [DATA_WIDTH-1:0]          o_write_data,
    output logic [IDW-1:0]                 o_grant_id
`ifdef RF_WB_FWD_EN
    ,
    input  logic [REG_ADDR-1:0]            i_read_register1_addr,
    input  logic [REG_ADDR-1:0]            i_read_register2_addr,
    output logic                           o_fwd_hit1,
    output logic                           o_fwd_hit2,
    output logic [DATA_WIDTH-1:0]          o_fwd_data
`endif
);

    localparam logic [IDW-1:0] RR_RESET = IDW'(NUM_REQ - 1);

    wb_req_t              req_s [NUM_REQ];
    wb_req_t              sel;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_idx;
    logic                 grant_valid;
    logic                 transfer;

    logic [IDW-1:0]       rr_last_q,  rr_last_d;
    logic                 wr_en_q,    wr_en_d;
    logic [REG_ADDR-1:0]  addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [IDW-1:0]       gid_q,      gid_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_s[gi] = {i_req_addr[gi*REG_ADDR +: REG_ADDR],
                                i_req_data[gi*DATA_WIDTH +: DATA_WIDTH]};
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i         (i_req_valid),
        .last_i        (rr_last_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Ready is suppressed while reset is held so no beat is accepted into a stage being cleared.
    assign o_req_ready = i_rst ? '0 : grant;
    assign transfer    = grant_valid && !i_rst;
    assign sel         = req_s[grant_idx];

    always_comb begin
        rr_last_d = rr_last_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        gid_d     = gid_q;
        if (transfer) begin
            rr_last_d = grant_idx;
            // x0 beats are consumed but never reach the register file.
            wr_en_d   = (sel.addr != '0);
            addr_d    = sel.addr;
            data_d    = sel.data;
            gid_d     = grant_idx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rr_last_q <= RR_RESET;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            gid_q     <= '0;
        end else begin
            rr_last_q <= rr_last_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            gid_q     <= gid_d;
        end
    end

    assign o_wr_reg_en           = wr_en_q;
    assign o_write_register_addr = addr_q;
    assign o_write_data          = data_q;
    assign o_grant_id            = gid_q;

`ifdef RF_WB_FWD_EN
    assign o_fwd_hit1 = wr_en_q && (i_read_register1_addr != '0)
                        && (i_read_register1_addr == addr_q);
    assign o_fwd_hit2 = wr_en_q && (i_read_register2_addr != '0)
                        && (i_read_register2_addr == addr_q);
    assign o_fwd_data = data_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin reference model.
module tb_regfile_wb_arbiter;

    localparam int N   = 2;
    localparam int AW  = 5;
    localparam int DW  = 32;

    logic              clk;
    logic              rst;
    logic [N-1:0]      valid;
    logic [N-1:0]      ready;
    logic [N*AW-1:0]   addr_f;
    logic [N*DW-1:0]   data_f;
    logic              wr_en;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [0:0]        gid;
`ifdef RF_WB_FWD_EN
    logic [AW-1:0]     rd1, rd2;
    logic              hit1, hit2;
    logic [DW-1:0]     fdata;
`endif

    logic [AW-1:0]     ra [N];
    logic [DW-1:0]     rdt [N];

    int checks;
    int failures;

    // Reference model state
    int          m_last;
    logic        m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int          m_gid;

    regfile_wb_arbiter #(.NUM_REQ(N)) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_req_valid           (valid),
        .o_req_ready           (ready),
        .i_req_addr            (addr_f),
        .i_req_data            (data_f),
        .o_wr_reg_en           (wr_en),
        .o_write_register_addr (waddr),
        .o_write_data          (wdata),
        .o_grant_id            (gid)
`ifdef RF_WB_FWD_EN
        ,
        .i_read_register1_addr (rd1),
        .i_read_register2_addr (rd2),
        .o_fwd_hit1            (hit1),
        .o_fwd_hit2            (hit2),
        .o_fwd_data            (fdata)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            addr_f[k*AW +: AW] = ra[k];
            data_f[k*DW +: DW] = rdt[k];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid = '0;
        for (int k = 0; k < N; k++) begin ra[k] = '0; rdt[k] = '0; end
        drive();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        m_last = N - 1; m_en = 1'b0; m_addr = '0; m_data = '0; m_gid = 0;
    endtask

    // Priority order is the list of requesters rotated to start just after the last winner.
    function automatic int model_pick(logic [N-1:0] v);
        int order[$];
        for (int k = 0; k < N; k++) order.push_back((m_last + 1 + k) % N);
        foreach (order[i]) if (v[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        valid = '1;
        ra[0] = 5'd3; ra[1] = 5'd4; rdt[0] = 32'h1; rdt[1] = 32'h2;
        drive();
        #2;
        checks++;
        if (ready !== '0) begin failures++; $display("FAIL reset_ready: got %b want 00", ready); end
        tick();
        checks++;
        if ({wr_en, waddr, wdata, gid} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%h gid=%0d want all 0", wr_en, waddr, wdata, gid);
        end
        valid = '0;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (wr_en !== 1'b0 || ready !== '0) begin
                failures++;
                $display("FAIL idle_cycle%0d: en=%b ready=%b want 0/00", c, wr_en, ready);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        valid = 2'b10; ra[1] = 5'd5; rdt[1] = 32'hDEADBEEF;
        drive();
        #2;
        checks++;
        if (ready !== 2'b10) begin failures++; $display("FAIL single_ready: got %b want 10", ready); end
        tick();
        valid = '0;
        checks++;
        if (wr_en !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF || gid !== 1'b1) begin
            failures++;
            $display("FAIL single_out: en=%b addr=%0d data=%h gid=%0d want 1/5/deadbeef/1", wr_en, waddr, wdata, gid);
        end
        tick();
        checks++;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL single_drop: en=%b want 0", wr_en); end
    endtask

    task automatic test_rotate();
        logic [N-1:0] exp_r;
        do_reset();
        valid = '1;
        for (int c = 0; c < 4; c++) begin
            ra[0] = 5'd10; ra[1] = 5'd11;
            rdt[0] = 32'hA000_0000 + c; rdt[1] = 32'hB000_0000 + c;
            drive();
            #2;
            exp_r = (c % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (ready !== exp_r) begin failures++; $display("FAIL rotate_ready%0d: got %b want %b", c, ready, exp_r); end
            tick();
            checks++;
            if (wr_en !== 1'b1 || gid !== 1'(c % 2) || waddr !== 5'(10 + c % 2)
                || wdata !== ((c % 2 == 0) ? 32'hA000_0000 + c : 32'hB000_0000 + c)) begin
                failures++;
                $display("FAIL rotate_out%0d: en=%b gid=%0d addr=%0d data=%h", c, wr_en, gid, waddr, wdata);
            end
        end
        valid = '0;
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        valid = 2'b01; ra[0] = 5'd0; rdt[0] = 32'h1234;
        drive();
        #2;
        checks++;
        if (ready !== 2'b01) begin failures++; $display("FAIL x0_ready: got %b want 01", ready); end
        tick();
        checks++;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL x0_en: got %b want 0", wr_en); end
        valid = 2'b11; ra[0] = 5'd2; rdt[0] = 32'h55; ra[1] = 5'd3; rdt[1] = 32'h66;
        drive();
        #2;
        checks++;
        if (ready !== 2'b10) begin failures++; $display("FAIL x0_next_grant: got %b want 10", ready); end
        tick();
        valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        valid = 2'b10; ra[1] = 5'd9; rdt[1] = 32'hCAFE;
        drive();
        tick();
        valid = '0;
        checks++;
        if (wr_en !== 1'b1) begin failures++; $display("FAIL midrst_pre: en=%b want 1", wr_en); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (wr_en !== 1'b0) begin failures++; $display("FAIL midrst_drop: en=%b want 0", wr_en); end
        tick();
        rst = 1'b0;
        valid = 2'b11; ra[0] = 5'd1; ra[1] = 5'd2;
        drive();
        #2;
        checks++;
        if (ready !== 2'b01) begin failures++; $display("FAIL midrst_prio: got %b want 01", ready); end
        valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic        pend [N];
        logic [N-1:0] exp_r;
        int          w;
        do_reset();
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) != 0) begin
                    pend[k] = 1'b1;
                    ra[k]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    rdt[k]  = $urandom;
                end
                valid[k] = pend[k];
            end
            drive();
            #2;
            w = model_pick(valid);
            exp_r = '0;
            if (w >= 0) exp_r[w] = 1'b1;
            checks++;
            if (ready !== exp_r) begin failures++; $display("FAIL rand_ready c=%0d: got %b want %b", c, ready, exp_r); end
            tick();
            if (w >= 0) begin
                m_en = (ra[w] != 0); m_addr = ra[w]; m_data = rdt[w]; m_gid = w;
                m_last = w; pend[w] = 1'b0;
            end else begin
                m_en = 1'b0;
            end
            checks++;
            if (wr_en !== m_en || waddr !== m_addr || wdata !== m_data || gid !== 1'(m_gid)) begin
                failures++;
                $display("FAIL rand_out c=%0d: got en=%b addr=%0d data=%h gid=%0d want %b/%0d/%h/%0d",
                         c, wr_en, waddr, wdata, gid, m_en, m_addr, m_data, m_gid);
            end
        end
        valid = '0;
        tick();
    endtask

`ifdef RF_WB_FWD_EN
    task automatic test_fwd();
        do_reset();
        valid = 2'b01; ra[0] = 5'd7; rdt[0] = 32'h0BAD_F00D;
        drive();
        tick();
        valid = '0;
        rd1 = 5'd7; rd2 = 5'd0;
        #1;
        checks++;
        if (hit1 !== 1'b1 || hit2 !== 1'b0 || fdata !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL fwd: hit1=%b hit2=%b data=%h want 1/0/0badf00d", hit1, hit2, fdata);
        end
        tick();
        checks++;
        if (hit1 !== 1'b0) begin failures++; $display("FAIL fwd_idle: hit1=%b want 0", hit1); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        valid = '0;
        addr_f = '0;
        data_f = '0;
        for (int k = 0; k < N; k++) begin ra[k] = '0; rdt[k] = '0; end
`ifdef RF_WB_FWD_EN
        rd1 = '0; rd2 = '0;
`endif
        #1;
        test_reset();
        test_single();
        test_rotate();
        test_x0();
        test_reset_mid();
        test_random();
`ifdef RF_WB_FWD_EN
        test_fwd();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
